// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: load-use, taken branch, data-memory wait and MDU occupancy.
// Define HAZARD_MDU_EN to build the multi-cycle MDU sequencer; otherwise mul/div is single-cycle.
`ifndef REG_FILE_ADDR_WIDTH
`define REG_FILE_ADDR_WIDTH 5
`endif

module hazard_unit #(
   parameter int MDU_LATENCY = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [`REG_FILE_ADDR_WIDTH-1:0] id_src1,
   input  logic [`REG_FILE_ADDR_WIDTH-1:0] id_src2,
   input  logic [`REG_FILE_ADDR_WIDTH-1:0] id_st_src,
   input  logic                            id_use1,
   input  logic                            id_use2,
   input  logic                            id_use_st,
   input  logic [`REG_FILE_ADDR_WIDTH-1:0] ex_dest,
   input  logic                            ex_mem_read,
   input  logic                            ex_mdu_op,
   input  logic                            ex_branch_taken,
   input  logic                            mem_wait,
   output logic                            pc_stall,
   output logic                            if_id_stall,
   output logic                            id_ex_stall,
   output logic                            ex_mem_stall,
   output logic                            if_id_flush,
   output logic                            id_ex_flush,
   output logic                            ex_mem_flush,
   output logic                            mem_wb_flush,
   output logic                            mdu_busy,
   output logic [31:0]                     stall_cycles
);

   logic        loaduse;
   logic        mdu_hold;
   logic [31:0] stall_cycles_reg;

   assign loaduse = ex_mem_read && (ex_dest != '0) &&
                    ((id_use1   && (id_src1   == ex_dest)) ||
                     (id_use2   && (id_src2   == ex_dest)) ||
                     (id_use_st && (id_st_src == ex_dest)));

`ifdef HAZARD_MDU_EN
   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // A data-memory wait freezes the sequencer so the stall length stretches with it.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (!mem_wait) begin
         case (state_reg)
            IDLE: begin
               if (ex_mdu_op) begin
                  state_next = BUSY;
                  cnt_next   = 8'(MDU_LATENCY - 1);
               end
            end
            BUSY: begin
               if (cnt_reg != 8'd0) cnt_next = cnt_reg - 8'd1;
               else                 state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign mdu_hold = ((state_reg == IDLE) && ex_mdu_op) ||
                     ((state_reg == BUSY) && (cnt_reg != 8'd0));
   assign mdu_busy = (state_reg == BUSY);
`else
   logic unused_mdu_op;
   assign unused_mdu_op = ex_mdu_op;
   assign mdu_hold      = 1'b0;
   assign mdu_busy      = 1'b0;
`endif

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      if (mem_wait) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (mdu_hold) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (loaduse) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles_reg <= 32'd0;
      else if (pc_stall && (stall_cycles_reg != 32'hFFFF_FFFF))
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
   end

   assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with MDU_LATENCY=4; expectations follow HAZARD_MDU_EN.
`ifndef REG_FILE_ADDR_WIDTH
`define REG_FILE_ADDR_WIDTH 5
`endif

module tb_hazard_unit;

   localparam int AW = `REG_FILE_ADDR_WIDTH;

   // Control vector: {pc_s, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, ex_mem_f, mem_wb_f, mdu_busy}
   localparam logic [8:0] NONE  = 9'b0_0000_0000;
   localparam logic [8:0] LU    = 9'b1_1000_1000;
   localparam logic [8:0] BR    = 9'b0_0001_1000;
   localparam logic [8:0] MW    = 9'b1_1110_0010;
`ifdef HAZARD_MDU_EN
   localparam logic [8:0] MDU_I = 9'b1_1100_0100;
   localparam logic [8:0] MDU_B = 9'b1_1100_0101;
   localparam logic [8:0] REL   = 9'b0_0000_0001;
   localparam logic [8:0] MW_B  = 9'b1_1110_0011;
`else
   localparam logic [8:0] MDU_I = NONE;
   localparam logic [8:0] MDU_B = NONE;
   localparam logic [8:0] REL   = NONE;
   localparam logic [8:0] MW_B  = MW;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] id_src1, id_src2, id_st_src, ex_dest;
   logic          id_use1, id_use2, id_use_st;
   logic          ex_mem_read, ex_mdu_op, ex_branch_taken, mem_wait;
   logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic          mdu_busy;
   logic [31:0]   stall_cycles;
   logic [8:0]    ctl;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   exp_cnt = 32'd0;

   hazard_unit #(.MDU_LATENCY(4)) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_st_src(id_st_src),
      .id_use1(id_use1), .id_use2(id_use2), .id_use_st(id_use_st),
      .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_mdu_op(ex_mdu_op),
      .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mdu_busy};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Called at a falling edge with inputs already set; checks, then advances one clock.
   task automatic cycle(input string tag, input logic [8:0] exp_ctl);
      #1;
      check({tag, ".ctl"}, {23'd0, ctl}, {23'd0, exp_ctl});
      check({tag, ".cnt"}, stall_cycles, exp_cnt);
      if (rst)                                        exp_cnt = 32'd0;
      else if (exp_ctl[8] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_src1 = '0; id_src2 = '0; id_st_src = '0; ex_dest = '0;
      id_use1 = 1'b0; id_use2 = 1'b0; id_use_st = 1'b0;
      ex_mem_read = 1'b0; ex_mdu_op = 1'b0; ex_branch_taken = 1'b0; mem_wait = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cycle("reset", NONE);

      // Load-use via src2, then the load moves to MEM
      ex_mem_read = 1'b1; ex_dest = AW'(5); id_src2 = AW'(5); id_use2 = 1'b1;
      id_src1 = AW'(3); id_use1 = 1'b1;
      cycle("lu_src2", LU);
      ex_mem_read = 1'b0; ex_dest = '0;
      cycle("lu_after", NONE);

      ex_mem_read = 1'b1; ex_dest = '0; id_src2 = '0;
      cycle("lu_dest0", NONE);
      ex_dest = AW'(5); id_src2 = AW'(5); id_use2 = 1'b0;
      cycle("lu_nouse", NONE);
      id_st_src = AW'(5); id_use_st = 1'b1;
      cycle("lu_st", LU);
      id_use_st = 1'b0; id_src1 = AW'(5);
      cycle("lu_src1", LU);

      ex_branch_taken = 1'b1;
      cycle("br_lu", BR);
      clear_inputs(); ex_branch_taken = 1'b1;
      cycle("br", BR);
      clear_inputs(); mem_wait = 1'b1;
      cycle("mw", MW);
      ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dest = AW'(7);
      id_src1 = AW'(7); id_use1 = 1'b1;
      cycle("mw_br_lu", MW);
      clear_inputs();

      // MDU op held in EX for the full occupancy
      ex_mdu_op = 1'b1;
      cycle("mdu1", MDU_I);
      cycle("mdu2", MDU_B);
      cycle("mdu3", MDU_B);
      cycle("mdu4", MDU_B);
      cycle("mdu_rel", REL);
      ex_mdu_op = 1'b0;
      cycle("mdu_done", NONE);

      // MDU with a 2-cycle memory wait during BUSY
      ex_mdu_op = 1'b1;
      cycle("mw_mdu1", MDU_I);
      cycle("mw_mdu2", MDU_B);
      mem_wait = 1'b1;
      cycle("mw_mdu_w1", MW_B);
      cycle("mw_mdu_w2", MW_B);
      mem_wait = 1'b0;
      cycle("mw_mdu3", MDU_B);
      cycle("mw_mdu4", MDU_B);
      cycle("mw_mdu_rel", REL);
      ex_mdu_op = 1'b0;
      cycle("mw_mdu_done", NONE);

      // Reset while BUSY with cnt=2
      ex_mdu_op = 1'b1;
      cycle("rb_mdu1", MDU_I);
      cycle("rb_mdu2", MDU_B);
      rst = 1'b1;
      cycle("rb_rst", MDU_B);
      rst = 1'b0; ex_mdu_op = 1'b0;
      cycle("rb_after", NONE);
      cycle("rb_after2", NONE);

      // Counter saturation from a preloaded value
      force dut.stall_cycles_reg = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cycles_reg;
      exp_cnt = 32'hFFFF_FFFE;
      mem_wait = 1'b1;
      cycle("sat1", MW);
      cycle("sat2", MW);
      cycle("sat3", MW);
      mem_wait = 1'b0;
      #1;
      check("sat_final", stall_cycles, 32'hFFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
